// File: rtl/eyeriss_pkg.sv
// Shared constants and types for the Eyeriss output-feature-map collector.
// Geometry: 62x46 output map, 3 PE rows per pass, 18-bit partial sums
// requantized to 8-bit pixels by a right shift of 10 plus saturation.
package eyeriss_pkg;

  localparam int unsigned OW     = 62;
  localparam int unsigned OH     = 46;
  localparam int unsigned ROWS   = 3;
  localparam int unsigned PSUM_W = 18;
  localparam int unsigned PIX_W  = 8;
  localparam int unsigned SHIFT  = 10;
  localparam int unsigned SAT_W  = 12;

  // Passes needed to cover OH rows; the last pass is ragged (one live lane).
  localparam int unsigned PASSES = (OH + ROWS - 1) / ROWS;

  localparam int unsigned COL_W  = $clog2(OW);
  localparam int unsigned PASS_W = $clog2(PASSES);
  localparam int unsigned ROW_W  = $clog2(ROWS * PASSES);
  localparam int unsigned RES_W  = OW * OH * PIX_W;
  localparam int unsigned ADDR_W = $clog2(RES_W);

  typedef enum logic [1:0] {
    IDLE,
    COLLECT,
    DONE
  } state_e;

endpackage

// File: rtl/eyeriss_ofmap_collector_if.sv
// Beat interface between the PE array (master) and the collector (slave).
//   in_valid : o_1..o_3 carry one column beat
//   in_ready : collector accepts the beat this cycle
//   o_1..o_3 : partial sums for rows 3*pass+0, +1, +2
interface eyeriss_ofmap_collector_if;
  import eyeriss_pkg::*;

  logic              in_valid;
  logic              in_ready;
  logic [PSUM_W-1:0] o_1;
  logic [PSUM_W-1:0] o_2;
  logic [PSUM_W-1:0] o_3;

  modport master (
    output in_valid,
    output o_1,
    output o_2,
    output o_3,
    input  in_ready
  );

  modport slave (
    input  in_valid,
    input  o_1,
    input  o_2,
    input  o_3,
    output in_ready
  );

endinterface

// File: rtl/eyeriss_requant.sv
// Combinational requantizer for one lane: unsigned right shift, then clamp
// to the pixel range.
//   sum : partial sum in
//   pix : requantized pixel
//   sat : high when the shifted value did not fit and was clamped
module eyeriss_requant #(
  parameter int unsigned PSUM_W = 18,
  parameter int unsigned PIX_W  = 8,
  parameter int unsigned SHIFT  = 10
) (
  input  logic [PSUM_W-1:0] sum,
  output logic [PIX_W-1:0]  pix,
  output logic              sat
);

  logic [PSUM_W-1:0] q;

  // Kept generic: with 18-bit sums and a 10-bit shift q never exceeds 255,
  // but other widths can overflow the pixel.
  assign q   = sum >> SHIFT;
  assign sat = q > PSUM_W'((1 << PIX_W) - 1);
  assign pix = sat ? '1 : q[PIX_W-1:0];

endmodule

// File: rtl/eyeriss_ofmap_collector.sv
// Receive end of the PE-array output path. Accepts one column beat of three
// row sums per handshake, requantizes each lane and writes it into the flat
// output map at (3*pass+k, col). Raises done once the last beat of the last
// pass is written.
//   clk, rst : clock, synchronous active-high reset
//   CE       : clock enable; low freezes everything and drops in_ready
//   start    : one-cycle pulse, (re)starts a frame
//   bus      : beat handshake and partial sums (slave side)
//   result   : flat map, pixel (r,c) at [(r*OW+c)*PIX_W +: PIX_W]
//   done     : level, frame complete
//   sat_cnt  : saturated pixels in the current frame (saturating count)
module eyeriss_ofmap_collector
  import eyeriss_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   CE,
  input  logic                   start,
  eyeriss_ofmap_collector_if.slave bus,
  output logic [RES_W-1:0]       result,
  output logic                   done,
  output logic [SAT_W-1:0]       sat_cnt
);

  state_e            state_q, state_d;
  logic [COL_W-1:0]  col_q, col_d;
  logic [PASS_W-1:0] pass_q, pass_d;
  logic [SAT_W-1:0]  sat_q, sat_d;
  logic [RES_W-1:0]  result_q;

  logic [PSUM_W-1:0] lane_sum [ROWS];
  logic [PIX_W-1:0]  lane_pix [ROWS];
  logic [ROW_W-1:0]  lane_row [ROWS];
  logic [ADDR_W-1:0] wr_base  [ROWS];
  logic [ROWS-1:0]   lane_sat;
  logic [ROWS-1:0]   lane_live;

  logic             ready;
  logic             accept;
  logic             last_col;
  logic             last_beat;
  logic [1:0]       sat_inc;
  logic [SAT_W:0]   sat_sum;

  assign lane_sum[0] = bus.o_1;
  assign lane_sum[1] = bus.o_2;
  assign lane_sum[2] = bus.o_3;

  for (genvar k = 0; k < ROWS; k++) begin : g_lane
    eyeriss_requant #(
      .PSUM_W(PSUM_W),
      .PIX_W (PIX_W),
      .SHIFT (SHIFT)
    ) u_requant (
      .sum(lane_sum[k]),
      .pix(lane_pix[k]),
      .sat(lane_sat[k])
    );

    assign lane_row[k]  = ROW_W'(ROWS * pass_q + k);
    // Rows past the map bottom (ragged last pass) are dropped entirely.
    assign lane_live[k] = lane_row[k] < ROW_W'(OH);
    assign wr_base[k]   = ADDR_W'((lane_row[k] * OW + col_q) * PIX_W);
  end

  assign ready        = CE && (state_q == COLLECT);
  assign bus.in_ready = ready;
  // start takes priority over a beat presented in the same cycle.
  assign accept       = ready && bus.in_valid && !start;
  assign last_col     = col_q == COL_W'(OW - 1);
  assign last_beat    = last_col && (pass_q == PASS_W'(PASSES - 1));

  always_comb begin
    sat_inc = '0;
    for (int k = 0; k < ROWS; k++) begin
      sat_inc = sat_inc + 2'(lane_live[k] & lane_sat[k]);
    end
    sat_sum = {1'b0, sat_q} + (SAT_W + 1)'(sat_inc);
  end

  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    pass_d  = pass_q;
    sat_d   = sat_q;

    if (CE && start) begin
      state_d = COLLECT;
      col_d   = '0;
      pass_d  = '0;
      sat_d   = '0;
    end else if (accept) begin
      sat_d = sat_sum[SAT_W] ? '1 : sat_sum[SAT_W-1:0];
      if (last_col) begin
        col_d  = '0;
        pass_d = pass_q + 1'b1;
      end else begin
        col_d = col_q + 1'b1;
      end
      if (last_beat) begin
        state_d = DONE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      col_q    <= '0;
      pass_q   <= '0;
      sat_q    <= '0;
      result_q <= '0;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      pass_q  <= pass_d;
      sat_q   <= sat_d;
      for (int k = 0; k < ROWS; k++) begin
        if (accept && lane_live[k]) begin
          result_q[wr_base[k] +: PIX_W] <= lane_pix[k];
        end
      end
    end
  end

  assign result  = result_q;
  assign done    = state_q == DONE;
  assign sat_cnt = sat_q;

endmodule

// File: tb/tb_eyeriss_ofmap_collector.sv
module tb_eyeriss_ofmap_collector;
  import eyeriss_pkg::*;

  localparam int BEATS = PASSES * OW;

  logic             clk = 1'b0;
  logic             rst;
  logic             CE;
  logic             start;
  logic [RES_W-1:0] result;
  logic             done;
  logic [11:0]      sat_cnt;

  int checks = 0;
  int errors = 0;

  eyeriss_ofmap_collector_if bus ();

  eyeriss_ofmap_collector dut (
    .clk    (clk),
    .rst    (rst),
    .CE     (CE),
    .start  (start),
    .bus    (bus),
    .result (result),
    .done   (done),
    .sat_cnt(sat_cnt)
  );

  always #5 clk = ~clk;

  // Reference model: the map as a 2-D pixel array plus a saturation tally.
  logic [7:0] exp_map [OH][OW];
  int         exp_sat;

  typedef struct {
    logic [17:0] o1, o2, o3;
    logic [7:0]  px0, px1, px2;   // expected pixel for rows r%3 == 0,1,2
    int          sat;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic model_beat(input int n, input logic [17:0] a, b, c);
    logic [17:0] v [3];
    int p, col, r, q;
    v[0] = a; v[1] = b; v[2] = c;
    p   = n / OW;
    col = n % OW;
    for (int k = 0; k < 3; k++) begin
      r = 3 * p + k;
      if (r < 46) begin
        q = int'(v[k] >> 10);
        if (q > 255) begin
          exp_map[r][col] = 8'd255;
          if (exp_sat < 4095) exp_sat++;
        end else begin
          exp_map[r][col] = 8'(q);
        end
      end
    end
  endtask

  task automatic check_map(input string name);
    int br, bc;
    logic [7:0] act;
    br = -1; bc = -1; act = '0;
    for (int r = 0; r < 46 && br < 0; r++) begin
      for (int c = 0; c < 62 && br < 0; c++) begin
        if (result[(r * 62 + c) * 8 +: 8] !== exp_map[r][c]) begin
          br = r; bc = c; act = result[(r * 62 + c) * 8 +: 8];
        end
      end
    end
    checks++;
    if (br >= 0) begin
      errors++;
      $display("FAIL %s pixel(%0d,%0d) actual=%0h required=%0h", name, br, bc, act,
               exp_map[br][bc]);
    end
  endtask

  // All tasks start and end at posedge+1.
  task automatic do_start(input bit with_beat);
    start = 1'b1;
    CE    = 1'b1;
    bus.in_valid = with_beat;
    bus.o_1 = 18'h3FFFF; bus.o_2 = 18'h3FFFF; bus.o_3 = 18'h3FFFF;
    @(posedge clk); #1;
    start = 1'b0;
    bus.in_valid = 1'b0;
    exp_sat = 0;
    check("start_done_low", done, 0);
    check("start_sat_clr", sat_cnt, 0);
    @(negedge clk);
    check("start_ready", bus.in_ready, 1);
    @(posedge clk); #1;
  endtask

  // mode 0: constant ca/cb/cc; 1: o_1=col, o_2=pass<<10, o_3=0; 2: random.
  task automatic run_beats(input int first, input int count, input int mode,
                           input logic [17:0] ca, cb, cc, input int stall_pct,
                           input bit chk_done);
    for (int n = first; n < first + count; n++) begin
      logic [17:0] a, b, c;
      bit acc;
      int budget;
      case (mode)
        1: begin a = 18'(n % OW); b = 18'((n / OW) << 10); c = '0; end
        2: begin a = 18'($urandom); b = 18'($urandom); c = 18'($urandom); end
        default: begin a = ca; b = cb; c = cc; end
      endcase
      bus.o_1 = a; bus.o_2 = b; bus.o_3 = c;
      acc = 1'b0;
      budget = 0;
      while (!acc) begin
        CE = ($urandom_range(99) >= stall_pct);
        bus.in_valid = ($urandom_range(99) >= stall_pct);
        @(negedge clk);
        check("in_ready_collect", bus.in_ready, CE);
        acc = CE && bus.in_valid && bus.in_ready;
        @(posedge clk); #1;
        budget++;
        if (!acc && budget > 200) begin
          errors++;
          $display("FAIL beat_timeout beat=%0d actual=no_accept required=accept", n);
          bus.in_valid = 1'b0; CE = 1'b1;
          return;
        end
      end
      model_beat(n, a, b, c);
      if (chk_done) check($sformatf("done_beat%0d", n), done, (n == BEATS - 1));
    end
    bus.in_valid = 1'b0;
    CE = 1'b1;
  endtask

  task automatic frame_end_checks(input string name);
    check_map({name, "_map"});
    check({name, "_sat"}, sat_cnt, exp_sat);
    check({name, "_done"}, done, 1);
    // Beats offered in DONE are refused and the map holds.
    bus.in_valid = 1'b1;
    bus.o_1 = 18'h3FFFF; bus.o_2 = 18'h3FFFF; bus.o_3 = 18'h3FFFF;
    repeat (2) begin
      @(negedge clk);
      check({name, "_done_ready"}, bus.in_ready, 0);
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b0;
    check_map({name, "_hold"});
  endtask

  vec_t vecs [4];

  initial begin
    vecs[0] = '{o1: 18'h00C00, o2: 18'h00C00, o3: 18'h00C00, px0: 8'd3, px1: 8'd3,
                px2: 8'd3, sat: 0};
    // 0x3FFFF >> 10 is exactly 255: maximum pixel, not an overflow.
    vecs[1] = '{o1: 18'h3FFFF, o2: 18'h00000, o3: 18'h00000, px0: 8'd255, px1: 8'd0,
                px2: 8'd0, sat: 0};
    vecs[2] = '{o1: 18'h003FF, o2: 18'h00400, o3: 18'h2AC00, px0: 8'd0, px1: 8'd1,
                px2: 8'd171, sat: 0};
    vecs[3] = '{o1: 18'h01400, o2: 18'h01400, o3: 18'h01400, px0: 8'd5, px1: 8'd5,
                px2: 8'd5, sat: 0};

    for (int r = 0; r < 46; r++)
      for (int c = 0; c < 62; c++) exp_map[r][c] = '0;
    exp_sat = 0;

    rst = 1'b1; CE = 1'b1; start = 1'b0;
    bus.in_valid = 1'b0; bus.o_1 = '0; bus.o_2 = '0; bus.o_3 = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    check_map("reset_map");
    check("reset_done", done, 0);
    check("reset_sat", sat_cnt, 0);
    @(negedge clk);
    check("reset_ready", bus.in_ready, 0);
    @(posedge clk); #1;

    // Beats without start are refused in IDLE.
    bus.in_valid = 1'b1; bus.o_1 = 18'h3FFFF;
    repeat (3) begin
      @(negedge clk);
      check("idle_ready", bus.in_ready, 0);
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b0;
    check_map("idle_map");

    // start is ignored while CE is low.
    CE = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    CE = 1'b1; start = 1'b0;
    @(negedge clk);
    check("ce_blocks_start", bus.in_ready, 0);
    @(posedge clk); #1;

    // Reset beats start.
    rst = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; start = 1'b0;
    @(negedge clk);
    check("rst_over_start", bus.in_ready, 0);
    @(posedge clk); #1;

    // Constant-input frames from the table.
    for (int i = 0; i < 4; i++) begin
      int br, bc;
      logic [7:0] want, got;
      do_start(0);
      run_beats(0, BEATS, 0, vecs[i].o1, vecs[i].o2, vecs[i].o3, 0, 1);
      br = -1; bc = -1; want = '0; got = '0;
      for (int r = 0; r < 46 && br < 0; r++) begin
        for (int c = 0; c < 62 && br < 0; c++) begin
          want = (r % 3 == 0) ? vecs[i].px0 : (r % 3 == 1) ? vecs[i].px1 : vecs[i].px2;
          got  = result[(r * 62 + c) * 8 +: 8];
          if (got !== want) begin br = r; bc = c; end
        end
      end
      checks++;
      if (br >= 0) begin
        errors++;
        $display("FAIL vec%0d_pixel(%0d,%0d) actual=%0h required=%0h", i, br, bc, got, want);
      end
      check($sformatf("vec%0d_sat", i), sat_cnt, vecs[i].sat);
      frame_end_checks($sformatf("vec%0d", i));
    end

    // Address mapping.
    do_start(0);
    run_beats(0, BEATS, 1, '0, '0, '0, 0, 1);
    frame_end_checks("addr");
    check("addr_r43_c61", result[(43 * 62 + 61) * 8 +: 8], 14);
    check("addr_r22_c5", result[(22 * 62 + 5) * 8 +: 8], 7);
    check("addr_r45_c61", result[(45 * 62 + 61) * 8 +: 8], 0);

    // Random data with ~30% CE and in_valid drops.
    do_start(0);
    run_beats(0, BEATS, 2, '0, '0, '0, 30, 1);
    frame_end_checks("random_stall");

    // Restart mid-frame; the start cycle also carries a beat that must be lost.
    do_start(0);
    run_beats(0, 500, 0, 18'h02400, 18'h02400, 18'h02400, 0, 0);
    check("mid_done_low", done, 0);
    do_start(1);
    run_beats(0, BEATS, 0, 18'h01400, 18'h01400, 18'h01400, 20, 1);
    frame_end_checks("restart");
    check("restart_r0_c0", result[7:0], 5);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
